// File: rtl/bmp_binarize_engine.sv
// bmp_binarize_engine: walks every BGR pixel of a BMP held in dual-port RAM,
// computes luma, thresholds it and writes 0x00/0xFF back to all three bytes.
module bmp_binarize_engine #(
    parameter int ADDR_WIDTH = 20,
    parameter int BYTE_WIDTH = 8,
    parameter int HDR_SIZE   = 54,
    parameter int IMG_W      = 512,
    parameter int IMG_H      = 512
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [7:0]            threshold,
    output logic                  busy,
    output logic                  done,
    output logic                  RAM_ren1,
    output logic                  RAM_wen1,
    output logic [ADDR_WIDTH-1:0] RAM_addr1,
    output logic [BYTE_WIDTH-1:0] RAM_in1,
    input  logic [BYTE_WIDTH-1:0] RAM_out1,
    output logic                  RAM_ren2,
    output logic                  RAM_wen2,
    output logic [ADDR_WIDTH-1:0] RAM_addr2,
    output logic [BYTE_WIDTH-1:0] RAM_in2
);
    localparam int ROW_BYTES = 3 * IMG_W;
    localparam int PAD       = (4 - ROW_BYTES % 4) % 4;
    localparam int CW        = IMG_W > 1 ? $clog2(IMG_W) : 1;
    localparam int RW        = IMG_H > 1 ? $clog2(IMG_H) : 1;

    typedef enum logic [3:0] {
        IDLE, RD_B, RD_G, RD_R, RD_W, CALC, WR_B, WR_G, WR_R, DONE
    } state_t;

    state_t state, state_nx;
    logic [ADDR_WIDTH-1:0] p;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [7:0] thr, b, g, r;
    logic [BYTE_WIDTH-1:0] bin;
    logic [15:0] sum;
    logic last_col, last_row;

    // Weights add up to 256, so the 16-bit sum never overflows and y <= 255.
    assign sum = 16'd77 * 16'(r) + 16'd150 * 16'(g) + 16'd29 * 16'(b);
    assign last_col = col == CW'(IMG_W - 1);
    assign last_row = row == RW'(IMG_H - 1);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? RD_B : IDLE;
            RD_B:    state_nx = RD_G;
            RD_G:    state_nx = RD_R;
            RD_R:    state_nx = RD_W;
            RD_W:    state_nx = CALC;
            CALC:    state_nx = WR_B;
            WR_B:    state_nx = WR_G;
            WR_G:    state_nx = WR_R;
            WR_R:    state_nx = (last_col && last_row) ? DONE : RD_B;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy      = state != IDLE;
        done      = state == DONE;
        RAM_ren1  = state inside {RD_B, RD_G, RD_R, RD_W};
        RAM_wen1  = 1'b0;
        RAM_in1   = '0;
        RAM_addr1 = state == RD_B ? p :
                    state == RD_G ? p + ADDR_WIDTH'(1) :
                    state inside {RD_R, RD_W} ? p + ADDR_WIDTH'(2) : '0;
        RAM_ren2  = 1'b0;
        RAM_wen2  = state inside {WR_B, WR_G, WR_R};
        RAM_in2   = RAM_wen2 ? bin : '0;
        RAM_addr2 = state == WR_B ? p :
                    state == WR_G ? p + ADDR_WIDTH'(1) :
                    state == WR_R ? p + ADDR_WIDTH'(2) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            p     <= '0;
            col   <= '0;
            row   <= '0;
            thr   <= '0;
            b     <= '0;
            g     <= '0;
            r     <= '0;
            bin   <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: if (start) begin
                    thr <= threshold;
                    p   <= ADDR_WIDTH'(HDR_SIZE);
                    col <= '0;
                    row <= '0;
                end
                RD_G: b <= RAM_out1[7:0];
                RD_R: g <= RAM_out1[7:0];
                RD_W: r <= RAM_out1[7:0];
                CALC: bin <= sum[15:8] >= thr ? '1 : '0;
                WR_R: if (!last_col) begin
                    p   <= p + ADDR_WIDTH'(3);
                    col <= col + CW'(1);
                end else if (!last_row) begin
                    p   <= p + ADDR_WIDTH'(3 + PAD);
                    col <= '0;
                    row <= row + RW'(1);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_bmp_binarize_engine.sv
// tb_bmp_binarize_engine: 2x2 image in a behavioural RAM, checked against
// a luma/threshold reference model and the expected cycle timing.
module tb_bmp_binarize_engine;
    localparam int AW = 20;
    localparam int W = 2;
    localparam int H = 2;
    localparam int HDR = 54;
    localparam int MEM = 128;
    localparam int STRIDE = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic [7:0] threshold = 8'd0;
    logic busy, done, ren1, wen1, ren2, wen2;
    logic [AW-1:0] addr1, addr2;
    logic [7:0] in1, in2, rdata;

    logic [7:0] mem [MEM];
    logic [7:0] exp_mem [MEM];
    int n_cmp = 0;
    int n_bad = 0;
    int oob = 0;

    always #5 clk = ~clk;

    bmp_binarize_engine #(.ADDR_WIDTH(AW), .BYTE_WIDTH(8), .HDR_SIZE(HDR),
                          .IMG_W(W), .IMG_H(H)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .threshold(threshold),
        .busy(busy), .done(done),
        .RAM_ren1(ren1), .RAM_wen1(wen1), .RAM_addr1(addr1), .RAM_in1(in1),
        .RAM_out1(rdata),
        .RAM_ren2(ren2), .RAM_wen2(wen2), .RAM_addr2(addr2), .RAM_in2(in2)
    );

    always @(posedge clk) begin
        if (ren1) begin
            if (addr1 >= AW'(MEM)) oob = oob + 1;
            else rdata <= mem[addr1[6:0]];
        end
        if (wen2) begin
            if (addr2 >= AW'(MEM)) oob = oob + 1;
            else mem[addr2[6:0]] = in2;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    function automatic int pix_addr(input int row, input int col);
        return HDR + row * STRIDE + col * 3;
    endfunction

    task automatic fill(input bit rnd, input logic [7:0] px [12]);
        for (int i = 0; i < MEM; i++) mem[i] = 8'hAA;
        for (int i = 0; i < W * H; i++)
            for (int c = 0; c < 3; c++)
                mem[pix_addr(i / W, i % W) + c] = rnd ? 8'($urandom) : px[i * 3 + c];
    endtask

    task automatic model(input logic [7:0] thr);
        int a, y;
        for (int i = 0; i < MEM; i++) exp_mem[i] = mem[i];
        for (int row = 0; row < H; row++)
            for (int col = 0; col < W; col++) begin
                a = pix_addr(row, col);
                y = (29 * int'(mem[a]) + 150 * int'(mem[a + 1]) + 77 * int'(mem[a + 2])) / 256;
                for (int c = 0; c < 3; c++) exp_mem[a + c] = (y >= int'(thr)) ? 8'hFF : 8'h00;
            end
    endtask

    task automatic compare_mem(input string tag);
        int bad = 0;
        for (int i = 0; i < MEM; i++)
            if (mem[i] !== exp_mem[i]) begin
                bad++;
                if (bad <= 4) $display("FAIL %s byte %0d: got %0h want %0h", tag, i, mem[i], exp_mem[i]);
            end
        chk({tag, "_mem"}, bad, 0);
        chk({tag, "_oob"}, oob, 0);
    endtask

    task automatic run(input logic [7:0] thr, input bit dbl, input bit abort, input string tag);
        int n_ren = 0, n_wen = 0, side = 0;
        logic [AW-1:0] first_rd = '1;
        model(thr);
        @(negedge clk);
        start = 1'b1;
        threshold = thr;
        @(negedge clk);
        start = 1'b0;
        threshold = 8'($urandom);
        for (int k = 1; k <= 40; k++) begin
            if (dbl && k == 4) begin start = 1'b1; threshold = 8'd0; end
            if (dbl && k == 5) start = 1'b0;
            if (abort && k == 10) begin
                #2 rst_n = 1'b0;
                #1;
                chk({tag, "_rst_busy"}, busy, 0);
                chk({tag, "_rst_done"}, done, 0);
                chk({tag, "_rst_en"}, {ren1, wen1, ren2, wen2}, 0);
                chk({tag, "_rst_addr"}, addr1 | addr2, 0);
                chk({tag, "_rst_data"}, {in1, in2}, 0);
                #1 rst_n = 1'b1;
                return;
            end
            chk($sformatf("%s_busy%0d", tag, k), busy, k <= 33);
            chk($sformatf("%s_done%0d", tag, k), done, k == 33);
            if (ren1) begin
                n_ren++;
                if (first_rd == '1) first_rd = addr1;
            end
            if (wen2) n_wen++;
            if (wen1 || ren2 || in1 != 0 || (ren1 && wen2)) side++;
            @(negedge clk);
        end
        chk({tag, "_ren1"}, n_ren, 16);
        chk({tag, "_wen2"}, n_wen, 12);
        chk({tag, "_first"}, first_rd, HDR);
        chk({tag, "_side"}, side, 0);
        compare_mem(tag);
    endtask

    initial begin
        logic [7:0] dir [12];
        logic [7:0] gray [12];
        dir = '{8'd0, 8'd0, 8'd255, 8'd255, 8'd255, 8'd255,
                8'd128, 8'd128, 8'd128, 8'd127, 8'd127, 8'd127};
        for (int i = 0; i < 12; i++) gray[i] = 8'd10;
        repeat (3) @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_out", {done, ren1, wen1, ren2, wen2, in1, in2}, 0);
        chk("reset_addr", addr1 | addr2, 0);
        rst_n = 1'b1;
        @(negedge clk);

        fill(1'b0, dir);
        run(8'd128, 1'b1, 1'b0, "luma");
        chk("luma_px0", mem[54], 8'h00);
        chk("luma_px2", mem[62], 8'hFF);
        chk("luma_px3", mem[65], 8'h00);
        chk("pad60", mem[60], 8'hAA);

        fill(1'b1, dir);
        run(8'd100, 1'b0, 1'b1, "abort");
        repeat (2) @(negedge clk);
        run(8'd100, 1'b0, 1'b0, "rerun");

        fill(1'b0, gray);
        run(8'd0, 1'b0, 1'b0, "thr0");
        fill(1'b0, gray);
        run(8'd255, 1'b0, 1'b0, "thr255");

        for (int t = 0; t < 4; t++) begin
            fill(1'b1, dir);
            run(8'($urandom), 1'b0, 1'b0, $sformatf("rand%0d", t));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
